mult_pipe_rv: RTL and testbench

- Parametrised, pipelined integer multiplier for the execute stage. Covers all four RV32M/RV64M multiply ops: MUL, MULH, MULHSU, MULHU.
- Per-stage valid, branch mask and tag travel with each op, so several independent ops are in flight at once.
- Valid/ready handshake on both sides, so writeback arbitration can stall the pipe without losing results.
- Mispredict squash and branch-mask bit clearing act per stage, not once per unit.

---
 rtl/mult_pkg.sv | 31 +++
 rtl/mult_pipe_stage.sv | 108 ++++++++++
 rtl/mult_pipe_rv.sv | 191 +++++++++++++++++++
 tb/tb_mult_pipe_rv.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined RV multiply unit.
package mult_pkg;

  // Multiply operation encoding as presented on in_func.
  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_func_t;

  // Widest operand the result selector handles; XLEN of any instance must not exceed it.
  localparam int MAX_XLEN = 64;

  // Picks the low half for MUL and the high half for the three MULH variants.
  // The product is passed zero-extended to the widest supported size, and the
  // caller truncates the returned value to its own XLEN.
  function automatic logic [MAX_XLEN-1:0] sel_result(
    input mul_func_t             func,
    input logic [2*MAX_XLEN-1:0] prod,
    input int                    xlen
  );
    logic [2*MAX_XLEN-1:0] hiPart;
    hiPart = prod >> xlen;
    if (func == MUL) begin
      return prod[MAX_XLEN-1:0];
    end
    return hiPart[MAX_XLEN-1:0];
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One shift-and-add step of the multiplier plus its pipeline register.
// The register carries valid, func, tag, branch mask and the running
// product/multiplicand/multiplier. Squash and branch-mask clear act here,
// on both the op entering the stage and the op held in it.
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_BITS  = 16,
  parameter int BMASK_W   = 8,
  parameter int TAG_W     = 6,
  parameter int CLR_PORTS = 2,
  localparam int PW       = 2 * XLEN,
  localparam int IDX_W    = $clog2(BMASK_W)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            i_advance,
  input  logic                            i_valid,
  input  mul_func_t                       i_func,
  input  logic [TAG_W-1:0]                i_tag,
  input  logic [BMASK_W-1:0]              i_bmask,
  input  logic [PW-1:0]                   i_prod,
  input  logic [PW-1:0]                   i_mcand,
  input  logic [PW-1:0]                   i_mplier,
  input  logic                            i_squashEn,
  input  logic [IDX_W-1:0]                i_squashIdx,
  input  logic [CLR_PORTS-1:0]            i_clrEn,
  input  logic [CLR_PORTS-1:0][IDX_W-1:0] i_clrIdx,
  output logic                            o_valid,
  output mul_func_t                       o_func,
  output logic [TAG_W-1:0]                o_tag,
  output logic [BMASK_W-1:0]              o_bmask,
  output logic [PW-1:0]                   o_prod,
  output logic [PW-1:0]                   o_mcand,
  output logic [PW-1:0]                   o_mplier
);

  typedef struct packed {
    logic               valid;
    mul_func_t          func;
    logic [TAG_W-1:0]   tag;
    logic [BMASK_W-1:0] bmask;
    logic [PW-1:0]      prod;
    logic [PW-1:0]      mcand;
    logic [PW-1:0]      mplier;
  } mul_stage_t;

  mul_stage_t         r_stage;
  logic [PW-1:0]      w_partial;
  logic [PW-1:0]      w_prodNext;
  logic [PW-1:0]      w_mcandNext;
  logic [PW-1:0]      w_mplierNext;
  logic [BMASK_W-1:0] w_clrMask;
  logic               w_inKill;
  logic               w_holdKill;

  // Consume the low NUM_BITS of the multiplier; everything wraps at 2*XLEN.
  always_comb begin
    w_partial    = PW'(i_mplier[NUM_BITS-1:0]) * i_mcand;
    w_prodNext   = i_prod + w_partial;
    w_mcandNext  = i_mcand << NUM_BITS;
    w_mplierNext = i_mplier >> NUM_BITS;
  end

  // Merge all resolve ports into one mask of bits to drop.
  always_comb begin
    w_clrMask = '0;
    for (int j = 0; j < CLR_PORTS; j++) begin
      if (i_clrEn[j]) begin
        w_clrMask[i_clrIdx[j]] = 1'b1;
      end
    end
  end

  // Kill decisions use the mask before this cycle's clear, so squash wins.
  always_comb begin
    w_inKill   = i_squashEn && i_bmask[i_squashIdx];
    w_holdKill = i_squashEn && r_stage.bmask[i_squashIdx];
  end

  // Load the next op on advance, otherwise hold; squash and clear apply either way.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
    end else if (i_advance) begin
      r_stage.valid  <= i_valid && !w_inKill;
      r_stage.func   <= i_func;
      r_stage.tag    <= i_tag;
      r_stage.bmask  <= i_bmask & ~w_clrMask;
      r_stage.prod   <= w_prodNext;
      r_stage.mcand  <= w_mcandNext;
      r_stage.mplier <= w_mplierNext;
    end else begin
      r_stage.valid  <= r_stage.valid && !w_holdKill;
      r_stage.bmask  <= r_stage.bmask & ~w_clrMask;
    end
  end

  assign o_valid  = r_stage.valid;
  assign o_func   = r_stage.func;
  assign o_tag    = r_stage.tag;
  assign o_bmask  = r_stage.bmask;
  assign o_prod   = r_stage.prod;
  assign o_mcand  = r_stage.mcand;
  assign o_mplier = r_stage.mplier;

endmodule

// File: rtl/mult_pipe_rv.sv
// Pipelined RV32M/RV64M multiplier (MUL, MULH, MULHSU, MULHU) with per-stage
// valid/tag/branch-mask, valid/ready on both ends and per-stage squash/clear.
// Optional build macro MULT_PIPE_PERF_CNT_EN adds perf_issued,
// perf_squashed and perf_stall_cycles counters.
module mult_pipe_rv
  import mult_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_STAGE = 4,
  parameter int BMASK_W   = 8,
  parameter int TAG_W     = 6,
  parameter int CLR_PORTS = 2
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [1:0]                              in_func,
  input  logic [XLEN-1:0]                         in_rs1,
  input  logic [XLEN-1:0]                         in_rs2,
  input  logic [BMASK_W-1:0]                      in_bmask,
  input  logic [TAG_W-1:0]                        in_tag,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [XLEN-1:0]                         out_result,
  output logic [TAG_W-1:0]                        out_tag,
  output logic [BMASK_W-1:0]                      out_bmask,
  input  logic                                    squash_en,
  input  logic [$clog2(BMASK_W)-1:0]              squash_idx,
  input  logic [CLR_PORTS-1:0]                    clr_en,
  input  logic [CLR_PORTS-1:0][$clog2(BMASK_W)-1:0] clr_idx
`ifdef MULT_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]                             perf_issued,
  output logic [31:0]                             perf_squashed,
  output logic [31:0]                             perf_stall_cycles
`endif
);

  localparam int PW       = 2 * XLEN;
  localparam int NUM_BITS = PW / NUM_STAGE;
  localparam int LAST     = NUM_STAGE - 1;

  typedef struct packed {
    logic               valid;
    mul_func_t          func;
    logic [TAG_W-1:0]   tag;
    logic [BMASK_W-1:0] bmask;
    logic [PW-1:0]      prod;
    logic [PW-1:0]      mcand;
    logic [PW-1:0]      mplier;
  } mul_stage_t;

  mul_stage_t              w_inOp;
  mul_stage_t              w_stage [NUM_STAGE];
  logic [NUM_STAGE-1:0]    w_adv;
  logic                    w_advAcc;
  logic                    w_lastKill;
  mul_func_t               w_inFunc;
  logic [2*MAX_XLEN-1:0]   w_prodWide;
  logic [MAX_XLEN-1:0]     w_resultWide;

  // Build the stage-0 operand set: rs1 signed for MULH/MULHSU, rs2 signed for MULH only.
  always_comb begin
    w_inFunc     = mul_func_t'(in_func);
    w_inOp       = '0;
    w_inOp.valid = in_valid;
    w_inOp.func  = w_inFunc;
    w_inOp.tag   = in_tag;
    w_inOp.bmask = in_bmask;
    w_inOp.prod  = '0;
    if (w_inFunc == MULH || w_inFunc == MULHSU) begin
      w_inOp.mcand = {{XLEN{in_rs1[XLEN-1]}}, in_rs1};
    end else begin
      w_inOp.mcand = {{XLEN{1'b0}}, in_rs1};
    end
    if (w_inFunc == MULH) begin
      w_inOp.mplier = {{XLEN{in_rs2[XLEN-1]}}, in_rs2};
    end else begin
      w_inOp.mplier = {{XLEN{1'b0}}, in_rs2};
    end
  end

  // A squash hitting the last stage hides its result this very cycle.
  always_comb begin
    w_lastKill = squash_en && w_stage[LAST].bmask[squash_idx];
    out_valid  = w_stage[LAST].valid && !w_lastKill;
  end

  // Bubble-collapsing advance chain, written as a running OR from the output back.
  always_comb begin
    w_adv    = '0;
    w_advAcc = !w_stage[LAST].valid || (out_valid && out_ready);
    w_adv[LAST] = w_advAcc;
    for (int i = LAST - 1; i >= 0; i--) begin
      w_advAcc = w_advAcc || !w_stage[i].valid;
      w_adv[i] = w_advAcc;
    end
  end

  assign in_ready = w_adv[0];

  genvar g;
  generate
    for (g = 0; g < NUM_STAGE; g++) begin : g_stage
      mul_stage_t w_prev;
      if (g == 0) begin : g_first
        assign w_prev = w_inOp;
      end else begin : g_rest
        assign w_prev = w_stage[g-1];
      end
      mult_pipe_stage #(
        .XLEN      (XLEN),
        .NUM_BITS  (NUM_BITS),
        .BMASK_W   (BMASK_W),
        .TAG_W     (TAG_W),
        .CLR_PORTS (CLR_PORTS)
      ) u_stage (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_advance   (w_adv[g]),
        .i_valid     (w_prev.valid),
        .i_func      (w_prev.func),
        .i_tag       (w_prev.tag),
        .i_bmask     (w_prev.bmask),
        .i_prod      (w_prev.prod),
        .i_mcand     (w_prev.mcand),
        .i_mplier    (w_prev.mplier),
        .i_squashEn  (squash_en),
        .i_squashIdx (squash_idx),
        .i_clrEn     (clr_en),
        .i_clrIdx    (clr_idx),
        .o_valid     (w_stage[g].valid),
        .o_func      (w_stage[g].func),
        .o_tag       (w_stage[g].tag),
        .o_bmask     (w_stage[g].bmask),
        .o_prod      (w_stage[g].prod),
        .o_mcand     (w_stage[g].mcand),
        .o_mplier    (w_stage[g].mplier)
      );
    end
  endgenerate

  // Select the requested half of the finished product from the last stage.
  always_comb begin
    w_prodWide   = (2*MAX_XLEN)'(w_stage[LAST].prod);
    w_resultWide = sel_result(w_stage[LAST].func, w_prodWide, XLEN);
    out_result   = w_resultWide[XLEN-1:0];
    out_tag      = w_stage[LAST].tag;
    out_bmask    = w_stage[LAST].bmask;
  end

`ifdef MULT_PIPE_PERF_CNT_EN
  localparam int KCNT_W = $clog2(NUM_STAGE + 2);

  logic [KCNT_W-1:0] w_killCnt;

  // Number of ops destroyed by squash this cycle, in flight or being accepted.
  always_comb begin
    w_killCnt = '0;
    if (squash_en) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        if (w_stage[i].valid && w_stage[i].bmask[squash_idx]) begin
          w_killCnt = w_killCnt + KCNT_W'(1);
        end
      end
      if (in_valid && in_ready && in_bmask[squash_idx]) begin
        w_killCnt = w_killCnt + KCNT_W'(1);
      end
    end
  end

  // Free-running wrapping event counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued       <= '0;
      perf_squashed     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (in_valid && in_ready) begin
        perf_issued <= perf_issued + 32'd1;
      end
      perf_squashed <= perf_squashed + 32'(w_killCnt);
      if (out_valid && !out_ready) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_pipe_rv.sv
// Directed bench for mult_pipe_rv with a scoreboard of expected results.
module tb_mult_pipe_rv;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_func;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [7:0]       in_bmask;
  logic [5:0]       in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [5:0]       out_tag;
  logic [7:0]       out_bmask;
  logic             squash_en;
  logic [2:0]       squash_idx;
  logic [1:0]       clr_en;
  logic [1:0][2:0]  clr_idx;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [7:0]  bmask;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   failures = 0;
  int   popCount = 0;

  mult_pipe_rv dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_bmask   (in_bmask),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_bmask  (out_bmask),
    .squash_en  (squash_en),
    .squash_idx (squash_idx),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference product using native 64-bit arithmetic.
  function automatic logic [31:0] modelResult(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sbv;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (f)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      2'd1: begin p = 64'(sa * sbv); return p[63:32]; end
      2'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      default: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [7:0] bm, input logic [5:0] tg);
    in_func  = f;
    in_rs1   = a;
    in_rs2   = b;
    in_bmask = bm;
    in_tag   = tg;
    in_valid = 1'b1;
  endtask

  task automatic waitAccept(output int waits);
    logic got;
    got   = 1'b0;
    waits = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    if (!got) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendOp(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] bm, input logic [5:0] tg, output int waits);
    applyStimulus(f, a, b, bm, tg);
    waitAccept(waits);
  endtask

  task automatic waitOutValid(output int lat);
    lat = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic waitDrain(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (scoreboard.size() == 0) break;
    end
    checkOutput(name, 64'(scoreboard.size()), 64'd0);
    repeat (6) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  // Scoreboard upkeep and result comparison, evaluated mid-cycle.
  always @(negedge clock) begin
    exp_t        e;
    logic [7:0]  bm;
    if (!reset_n) begin
      scoreboard.delete();
    end else begin
      if (squash_en) begin
        for (int i = scoreboard.size() - 1; i >= 0; i--) begin
          if (scoreboard[i].bmask[squash_idx]) scoreboard.delete(i);
        end
      end
      if (out_valid && out_ready) begin
        popCount++;
        if (scoreboard.size() == 0) begin
          checkOutput("unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          e = scoreboard.pop_front();
          checkOutput("sb_result", 64'(out_result), 64'(e.res));
          checkOutput("sb_tag", 64'(out_tag), 64'(e.tag));
          checkOutput("sb_bmask", 64'(out_bmask), 64'(e.bmask));
        end
      end
      for (int j = 0; j < 2; j++) begin
        if (clr_en[j]) begin
          for (int i = 0; i < scoreboard.size(); i++) scoreboard[i].bmask[clr_idx[j]] = 1'b0;
        end
      end
      if (in_valid && in_ready && !(squash_en && in_bmask[squash_idx])) begin
        bm = in_bmask;
        for (int j = 0; j < 2; j++) if (clr_en[j]) bm[clr_idx[j]] = 1'b0;
        e.res   = modelResult(in_func, in_rs1, in_rs2);
        e.tag   = in_tag;
        e.bmask = bm;
        scoreboard.push_back(e);
      end
    end
  end

  initial begin
    int          w;
    int          lat;
    int          popSnap;
    logic [31:0] expRes;
    logic [5:0]  expTag;

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_func    = 2'd0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_bmask   = '0;
    in_tag     = '0;
    out_ready  = 1'b1;
    squash_en  = 1'b0;
    squash_idx = '0;
    clr_en     = '0;
    clr_idx    = '0;

    #2;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_result", 64'(out_result), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset_out_bmask", 64'(out_bmask), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Basic MUL, latency and tag.
    sendOp(2'd0, 32'd7, 32'd6, 8'h00, 6'd5, w);
    waitOutValid(lat);
    checkOutput("mul_latency", 64'(lat), 64'd4);
    checkOutput("mul_result", 64'(out_result), 64'd42);
    checkOutput("mul_tag", 64'(out_tag), 64'd5);
    waitDrain("mul_drain");

    // High-half variants on all-ones operands.
    sendOp(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 6'd6, w);
    sendOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 6'd7, w);
    sendOp(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 6'd8, w);
    sendOp(2'd1, 32'h8000_0000, 32'h7FFF_FFFF, 8'h00, 6'd9, w);
    waitDrain("high_drain");

    // Fill under backpressure, stall, then release.
    out_ready = 1'b0;
    sendOp(2'd0, 32'd11, 32'd13, 8'h00, 6'd1, w);
    checkOutput("fill_wait0", 64'(w), 64'd0);
    sendOp(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 6'd2, w);
    checkOutput("fill_wait1", 64'(w), 64'd0);
    sendOp(2'd1, 32'hDEAD_BEEF, 32'h0000_1000, 8'h00, 6'd3, w);
    checkOutput("fill_wait2", 64'(w), 64'd0);
    sendOp(2'd2, 32'hFFFF_FFF0, 32'h8000_0001, 8'h00, 6'd4, w);
    checkOutput("fill_wait3", 64'(w), 64'd0);
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'd3, 8'h00, 6'd10);
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      expRes = (scoreboard.size() != 0) ? scoreboard[0].res : 32'hFFFF_FFFF;
      expTag = (scoreboard.size() != 0) ? scoreboard[0].tag : 6'h3F;
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_result", 64'(out_result), 64'(expRes));
      checkOutput("stall_tag", 64'(out_tag), 64'(expTag));
      tick();
    end
    out_ready = 1'b1;
    waitAccept(w);
    sendOp(2'd3, 32'd100, 32'd200, 8'h00, 6'd11, w);
    waitDrain("stall_drain");

    // Squash on bit 0 with three ops in flight.
    out_ready = 1'b0;
    sendOp(2'd0, 32'd2, 32'd3, 8'h01, 6'd12, w);
    sendOp(2'd0, 32'd4, 32'd5, 8'h02, 6'd13, w);
    sendOp(2'd0, 32'd6, 32'd7, 8'h01, 6'd14, w);
    tick();
    squash_en  = 1'b1;
    squash_idx = 3'd0;
    @(negedge clock);
    checkOutput("squash_mask_out", 64'(out_valid), 64'd0);
    tick();
    squash_en = 1'b0;
    popSnap   = popCount;
    out_ready = 1'b1;
    waitDrain("squash_drain");
    checkOutput("squash_survivors", 64'(popCount - popSnap), 64'd1);

    // Squash and clear on the same bit in the same cycle.
    out_ready = 1'b0;
    sendOp(2'd0, 32'd9, 32'd9, 8'h02, 6'd20, w);
    waitOutValid(lat);
    tick();
    clr_en     = 2'b01;
    clr_idx    = {3'd0, 3'd1};
    squash_en  = 1'b1;
    squash_idx = 3'd1;
    @(negedge clock);
    checkOutput("sqclr_mask_out", 64'(out_valid), 64'd0);
    tick();
    clr_en    = 2'b00;
    squash_en = 1'b0;
    @(negedge clock);
    checkOutput("sqclr_killed", 64'(out_valid), 64'd0);
    tick();
    popSnap   = popCount;
    out_ready = 1'b1;
    waitDrain("sqclr_drain");
    checkOutput("sqclr_no_result", 64'(popCount - popSnap), 64'd0);

    // Clear alone: mask bit drops a cycle later, result untouched.
    out_ready = 1'b0;
    sendOp(2'd3, 32'h0001_0000, 32'h0003_0000, 8'h06, 6'd21, w);
    waitOutValid(lat);
    checkOutput("clr_bmask_before", 64'(out_bmask), 64'h06);
    tick();
    clr_en  = 2'b01;
    clr_idx = {3'd0, 3'd1};
    @(negedge clock);
    checkOutput("clr_bmask_same_cycle", 64'(out_bmask), 64'h06);
    tick();
    clr_en = 2'b00;
    @(negedge clock);
    checkOutput("clr_bmask_after", 64'(out_bmask), 64'h04);
    checkOutput("clr_result", 64'(out_result), 64'd3);
    tick();
    out_ready = 1'b1;
    waitDrain("clr_drain");

    // Reset mid-flight drops everything.
    out_ready = 1'b0;
    sendOp(2'd0, 32'd21, 32'd2, 8'h00, 6'd25, w);
    sendOp(2'd0, 32'd22, 32'd2, 8'h00, 6'd26, w);
    sendOp(2'd0, 32'd23, 32'd2, 8'h00, 6'd27, w);
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    popSnap   = popCount;
    out_ready = 1'b1;
    repeat (8) @(negedge clock);
    checkOutput("midreset_quiet", 64'(out_valid), 64'd0);
    checkOutput("midreset_no_result", 64'(popCount - popSnap), 64'd0);
    tick();
    sendOp(2'd0, 32'd3, 32'd5, 8'h00, 6'd30, w);
    waitOutValid(lat);
    checkOutput("post_reset_result", 64'(out_result), 64'd15);
    waitDrain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
